// File: rtl/alarm_bank.sv
// Multi-channel hour:minute alarm bank sharing one ringer with stop, snooze,
// auto-timeout and a pending queue for matches that arrive while the ringer is busy.
module alarm_bank #(
  parameter int N_ALARMS   = 4,
  parameter int HOURS      = 24,
  parameter int MINS       = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_TMO_S = 60,
  localparam int IDX_W     = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1,
  localparam int HOUR_W    = $clog2(HOURS),
  localparam int MIN_W     = $clog2(MINS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick_1s,
  input  logic [HOUR_W-1:0]   cur_hour,
  input  logic [MIN_W-1:0]    cur_min,
  input  logic [MIN_W-1:0]    cur_sec,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [HOUR_W-1:0]   wr_hour,
  input  logic [MIN_W-1:0]    wr_min,
  input  logic                wr_on,
  input  logic [IDX_W-1:0]    rd_idx,
  input  logic                ack_stop,
  input  logic                ack_snooze,
  output logic [HOUR_W-1:0]   rd_hour,
  output logic [MIN_W-1:0]    rd_min,
  output logic [N_ALARMS-1:0] armed,
  output logic                ring,
  output logic [IDX_W-1:0]    ring_idx,
  output logic                snoozing,
  output logic [1:0]          state_dbg
);

  localparam int TMR_W = $clog2(RING_TMO_S + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RINGING = 2'd1,
    S_SNOOZED = 2'd2
  } state_t;

  state_t state, next_state;

  logic [HOUR_W-1:0]   alm_hour [N_ALARMS];
  logic [MIN_W-1:0]    alm_min  [N_ALARMS];
  logic [N_ALARMS-1:0] pending, pending_next, match;
  logic [IDX_W-1:0]    next_idx, grant_idx;
  logic                grant, snz_load, any_pend;
  logic                tick0, wr_ok, wr_off, cancel, snz_match, tmo;
  logic [HOUR_W-1:0]   snz_hour, snz_hour_calc;
  logic [MIN_W-1:0]    snz_min, snz_min_calc;
  logic [MIN_W:0]      min_sum;
  logic [TMR_W-1:0]    timer;

  // Alarms only fire on the tick that starts a new minute.
  assign tick0     = tick_1s && (cur_sec == '0);
  assign wr_ok     = wr_en && (32'(wr_idx) < N_ALARMS);
  assign wr_off    = wr_ok && !wr_on;
  assign cancel    = wr_off && (wr_idx == ring_idx);
  assign snz_match = tick0 && (snz_hour == cur_hour) && (snz_min == cur_min);
  assign tmo       = tick_1s && (timer == TMR_W'(RING_TMO_S - 1));
  assign any_pend  = |pending;
  assign state_dbg = state;

  always_comb begin
    match = '0;
    for (int k = 0; k < N_ALARMS; k++) begin
      match[k] = tick0 && armed[k] && (alm_hour[k] == cur_hour) && (alm_min[k] == cur_min);
    end
  end

  // Lowest pending index wins.
  always_comb begin
    grant_idx = '0;
    for (int k = N_ALARMS - 1; k >= 0; k--) begin
      if (pending[k]) grant_idx = IDX_W'(k);
    end
  end

  always_comb begin
    min_sum       = {1'b0, cur_min} + (MIN_W+1)'(SNOOZE_MIN);
    snz_min_calc  = min_sum[MIN_W-1:0];
    snz_hour_calc = cur_hour;
    if (min_sum >= (MIN_W+1)'(MINS)) begin
      snz_min_calc  = MIN_W'(min_sum - (MIN_W+1)'(MINS));
      snz_hour_calc = (cur_hour == HOUR_W'(HOURS - 1)) ? '0 : cur_hour + HOUR_W'(1);
    end
  end

  always_comb begin
    next_state = state;
    next_idx   = ring_idx;
    grant      = 1'b0;
    snz_load   = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_pend) begin
          next_state = S_RINGING;
          next_idx   = grant_idx;
          grant      = 1'b1;
        end
      end
      S_RINGING: begin
        if (ack_stop || tmo || cancel) begin
          next_state = S_IDLE;
        end else if (ack_snooze) begin
          next_state = S_SNOOZED;
          snz_load   = 1'b1;
        end
      end
      S_SNOOZED: begin
        if (ack_stop || cancel) begin
          next_state = S_IDLE;
        end else if (snz_match) begin
          next_state = S_RINGING;
        end else if (any_pend) begin
          next_state = S_RINGING;
          next_idx   = grant_idx;
          grant      = 1'b1;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // A disabling write overrides any match landing on the same edge.
  always_comb begin
    pending_next = pending;
    if (grant) pending_next[next_idx] = 1'b0;
    for (int k = 0; k < N_ALARMS; k++) begin
      if (match[k] && !((state == S_RINGING) && (ring_idx == IDX_W'(k))))
        pending_next[k] = 1'b1;
    end
    if (wr_off) pending_next[wr_idx] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      ring_idx <= '0;
      ring     <= 1'b0;
      snoozing <= 1'b0;
      pending  <= '0;
      armed    <= '0;
      timer    <= '0;
      snz_hour <= '0;
      snz_min  <= '0;
      for (int k = 0; k < N_ALARMS; k++) begin
        alm_hour[k] <= '0;
        alm_min[k]  <= '0;
      end
    end else begin
      state    <= next_state;
      ring_idx <= next_idx;
      ring     <= (next_state == S_RINGING);
      snoozing <= (next_state == S_SNOOZED);
      pending  <= pending_next;
      if (snz_load) begin
        snz_hour <= snz_hour_calc;
        snz_min  <= snz_min_calc;
      end
      if ((next_state == S_RINGING) && (state != S_RINGING))
        timer <= '0;
      else if ((state == S_RINGING) && tick_1s)
        timer <= timer + TMR_W'(1);
      if (wr_ok) begin
        alm_hour[wr_idx] <= wr_hour;
        alm_min[wr_idx]  <= wr_min;
        armed[wr_idx]    <= wr_on;
      end
    end
  end

  always_comb begin
    rd_hour = '0;
    rd_min  = '0;
    if (32'(rd_idx) < N_ALARMS) begin
      rd_hour = alm_hour[rd_idx];
      rd_min  = alm_min[rd_idx];
    end
  end

endmodule

// File: tb/tb_alarm_bank.sv
// Directed bench for alarm_bank: a vector table for single-cycle behaviour plus
// hand-written sequences for ring timeout and asynchronous reset.
module tb_alarm_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_1s;
  logic [4:0] cur_hour;
  logic [5:0] cur_min, cur_sec;
  logic       wr_en;
  logic [1:0] wr_idx;
  logic [4:0] wr_hour;
  logic [5:0] wr_min;
  logic       wr_on;
  logic [1:0] rd_idx;
  logic       ack_stop, ack_snooze;
  logic [4:0] rd_hour;
  logic [5:0] rd_min;
  logic [3:0] armed;
  logic       ring;
  logic [1:0] ring_idx;
  logic       snoozing;
  logic [1:0] state_dbg;

  int n_vec = 0;
  int n_err = 0;

  alarm_bank dut (
    .clk(clk), .rst(rst), .tick_1s(tick_1s),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_hour(wr_hour), .wr_min(wr_min), .wr_on(wr_on),
    .rd_idx(rd_idx), .ack_stop(ack_stop), .ack_snooze(ack_snooze),
    .rd_hour(rd_hour), .rd_min(rd_min), .armed(armed), .ring(ring),
    .ring_idx(ring_idx), .snoozing(snoozing), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       tk;
    logic [4:0] h;
    logic [5:0] m, s;
    logic       w;
    logic [1:0] wi;
    logic [4:0] wh;
    logic [5:0] wm;
    logic       wo;
    logic [1:0] ri;
    logic       st, sn;
    logic       e_ring;
    logic [1:0] e_idx;
    logic       e_snz;
    logic [3:0] e_armed;
    logic [4:0] e_rhr;
    logic [5:0] e_rmn;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, bit tk, int h, int m, int s,
                              bit w, int wi, int wh, int wm, bit wo, int ri, bit st, bit sn,
                              bit er, int ei, bit es, logic [3:0] ea, int erh, int erm);
    vec_t v;
    v.name = n; v.tk = tk; v.h = 5'(h); v.m = 6'(m); v.s = 6'(s);
    v.w = w; v.wi = 2'(wi); v.wh = 5'(wh); v.wm = 6'(wm); v.wo = wo;
    v.ri = 2'(ri); v.st = st; v.sn = sn;
    v.e_ring = er; v.e_idx = 2'(ei); v.e_snz = es; v.e_armed = ea;
    v.e_rhr = 5'(erh); v.e_rmn = 6'(erm);
    return v;
  endfunction

  task automatic set_in(input bit tk, input int h, input int m, input int s,
                        input bit w, input int wi, input int wh, input int wm, input bit wo,
                        input int ri, input bit st, input bit sn);
    tick_1s = tk; cur_hour = 5'(h); cur_min = 6'(m); cur_sec = 6'(s);
    wr_en = w; wr_idx = 2'(wi); wr_hour = 5'(wh); wr_min = 6'(wm); wr_on = wo;
    rd_idx = 2'(ri); ack_stop = st; ack_snooze = sn;
  endtask

  task automatic check_out(input string name, input logic e_ring, input logic [1:0] e_idx,
                           input logic e_snz, input logic [3:0] e_armed,
                           input logic [4:0] e_rhr, input logic [5:0] e_rmn);
    logic [1:0] e_st;
    e_st = e_ring ? 2'd1 : (e_snz ? 2'd2 : 2'd0);
    n_vec++;
    if ({ring, ring_idx, snoozing, armed, rd_hour, rd_min, state_dbg} !==
        {e_ring, e_idx, e_snz, e_armed, e_rhr, e_rmn, e_st}) begin
      n_err++;
      $display("FAIL %s: got ring=%0d idx=%0d snz=%0d armed=%b rd=%0d:%0d st=%0d, want ring=%0d idx=%0d snz=%0d armed=%b rd=%0d:%0d st=%0d",
               name, ring, ring_idx, snoozing, armed, rd_hour, rd_min, state_dbg,
               e_ring, e_idx, e_snz, e_armed, e_rhr, e_rmn, e_st);
    end
  endtask

  initial begin
    bit hold_ok;

    //             name           tk  h  m  s  w wi wh wm wo ri st sn | ring idx snz armed    rd_h rd_m
    vecs.push_back(mk("wr_ch1",       0, 0, 0, 1, 1, 1, 7,30, 1, 1, 0, 0,  0, 0, 0, 4'b0010,  7, 30));
    vecs.push_back(mk("wr_ch0",       0, 0, 0, 1, 1, 0,23,58, 1, 0, 0, 0,  0, 0, 0, 4'b0011, 23, 58));
    vecs.push_back(mk("wr_ch3",       0, 0, 0, 1, 1, 3, 6, 0, 1, 3, 0, 0,  0, 0, 0, 4'b1011,  6,  0));
    vecs.push_back(mk("wr_ch2",       0, 0, 0, 1, 1, 2,12, 0, 1, 2, 0, 0,  0, 0, 0, 4'b1111, 12,  0));
    vecs.push_back(mk("no_tick",      0, 7,30, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 4'b1111,  7, 30));
    vecs.push_back(mk("sec_nonzero",  1, 7,30, 1, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 4'b1111,  7, 30));
    vecs.push_back(mk("t1_match",     1, 7,30, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 4'b1111,  7, 30));
    vecs.push_back(mk("t1_ring",      0, 7,30, 1, 0, 0, 0, 0, 0, 1, 0, 0,  1, 1, 0, 4'b1111,  7, 30));
    vecs.push_back(mk("t1_hold",      0, 7,30, 5, 0, 0, 0, 0, 0, 1, 0, 0,  1, 1, 0, 4'b1111,  7, 30));
    vecs.push_back(mk("t1_stop",      0, 7,30, 6, 0, 0, 0, 0, 0, 1, 1, 0,  0, 1, 0, 4'b1111,  7, 30));
    vecs.push_back(mk("t1_idle",      0, 7,30, 7, 0, 0, 0, 0, 0, 1, 0, 0,  0, 1, 0, 4'b1111,  7, 30));
    vecs.push_back(mk("t2_match",     1,23,58, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 4'b1111, 23, 58));
    vecs.push_back(mk("t2_ring",      0,23,58, 1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 4'b1111, 23, 58));
    vecs.push_back(mk("t2_snooze",    0,23,58,30, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 4'b1111, 23, 58));
    vecs.push_back(mk("t2_early",     1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 4'b1111, 23, 58));
    vecs.push_back(mk("t2_snz_match", 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 4'b1111, 23, 58));
    vecs.push_back(mk("t2_stop",      0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 4'b1111, 23, 58));
    vecs.push_back(mk("t4_wr0",       0, 0, 3, 2, 1, 0, 6, 0, 1, 0, 0, 0,  0, 0, 0, 4'b1111,  6,  0));
    vecs.push_back(mk("t4_match",     1, 6, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0,  0, 0, 0, 4'b1111,  6,  0));
    vecs.push_back(mk("t4_ring0",     0, 6, 0, 1, 0, 0, 0, 0, 0, 3, 0, 0,  1, 0, 0, 4'b1111,  6,  0));
    vecs.push_back(mk("t4_stop",      0, 6, 0, 2, 0, 0, 0, 0, 0, 3, 1, 0,  0, 0, 0, 4'b1111,  6,  0));
    vecs.push_back(mk("t4_ring3",     0, 6, 0, 3, 0, 0, 0, 0, 0, 3, 0, 0,  1, 3, 0, 4'b1111,  6,  0));
    vecs.push_back(mk("t5a_both",     0, 6, 0, 4, 0, 0, 0, 0, 0, 3, 1, 1,  0, 3, 0, 4'b1111,  6,  0));
    vecs.push_back(mk("t5a_idle",     0, 6, 0, 5, 0, 0, 0, 0, 0, 3, 0, 0,  0, 3, 0, 4'b1111,  6,  0));
    vecs.push_back(mk("t5b_match",    1,12, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0,  0, 3, 0, 4'b1111, 12,  0));
    vecs.push_back(mk("t5b_ring",     0,12, 0, 1, 0, 0, 0, 0, 0, 2, 0, 0,  1, 2, 0, 4'b1111, 12,  0));
    vecs.push_back(mk("t5b_rewrite",  0,12, 0, 2, 1, 2,13,15, 1, 2, 0, 0,  1, 2, 0, 4'b1111, 13, 15));
    vecs.push_back(mk("t5b_cancel",   0,12, 0, 3, 1, 2,13,15, 0, 2, 0, 0,  0, 2, 0, 4'b1011, 13, 15));
    vecs.push_back(mk("t5b_idle",     0,12, 0, 4, 0, 0, 0, 0, 0, 2, 0, 0,  0, 2, 0, 4'b1011, 13, 15));
    vecs.push_back(mk("ab_match",     1, 7,30, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 2, 0, 4'b1011,  7, 30));
    vecs.push_back(mk("ab_ring",      0, 7,30, 1, 0, 0, 0, 0, 0, 1, 0, 0,  1, 1, 0, 4'b1011,  7, 30));
    vecs.push_back(mk("ab_absorb",    1, 7,30, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 1, 0, 4'b1011,  7, 30));
    vecs.push_back(mk("ab_stop",      0, 7,30, 1, 0, 0, 0, 0, 0, 1, 1, 0,  0, 1, 0, 4'b1011,  7, 30));
    vecs.push_back(mk("ab_nopend",    0, 7,30, 2, 0, 0, 0, 0, 0, 1, 0, 0,  0, 1, 0, 4'b1011,  7, 30));
    vecs.push_back(mk("sc_match",     1, 7,30, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 1, 0, 4'b1011,  7, 30));
    vecs.push_back(mk("sc_ring",      0, 7,30, 1, 0, 0, 0, 0, 0, 1, 0, 0,  1, 1, 0, 4'b1011,  7, 30));
    vecs.push_back(mk("sc_snooze",    0, 7,30,10, 0, 0, 0, 0, 0, 1, 0, 1,  0, 1, 1, 4'b1011,  7, 30));
    vecs.push_back(mk("sc_cancel",    0, 7,30,11, 1, 1, 7,30, 0, 1, 0, 0,  0, 1, 0, 4'b1001,  7, 30));
    vecs.push_back(mk("sp_match",     1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 4'b1001,  6,  0));
    vecs.push_back(mk("sp_ring0",     0, 6, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 4'b1001,  6,  0));
    vecs.push_back(mk("sp_snooze",    0, 6, 0, 5, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 4'b1001,  6,  0));
    vecs.push_back(mk("sp_preempt",   0, 6, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0,  1, 3, 0, 4'b1001,  6,  0));
    vecs.push_back(mk("sp_stop",      0, 6, 0, 7, 0, 0, 0, 0, 0, 0, 1, 0,  0, 3, 0, 4'b1001,  6,  0));
    vecs.push_back(mk("sp_idle",      0, 6, 0, 8, 0, 0, 0, 0, 0, 0, 0, 0,  0, 3, 0, 4'b1001,  6,  0));

    // Clock/reset
    rst = 1'b0;
    set_in(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 check_out("reset", 0, 0, 0, 4'b0000, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      set_in(vecs[i].tk, vecs[i].h, vecs[i].m, vecs[i].s, vecs[i].w, vecs[i].wi,
             vecs[i].wh, vecs[i].wm, vecs[i].wo, vecs[i].ri, vecs[i].st, vecs[i].sn);
      @(posedge clk);
      #1 check_out(vecs[i].name, vecs[i].e_ring, vecs[i].e_idx, vecs[i].e_snz,
                   vecs[i].e_armed, vecs[i].e_rhr, vecs[i].e_rmn);
    end

    // Timeout: ring ch2, then count ticks with no acknowledge.
    @(negedge clk);
    set_in(0, 12, 0, 1, 1, 2, 12, 0, 1, 2, 0, 0);
    @(posedge clk);
    #1 check_out("t3_wr", 0, 3, 0, 4'b1101, 12, 0);
    @(negedge clk);
    set_in(1, 12, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
    @(posedge clk);
    #1 check_out("t3_match", 0, 3, 0, 4'b1101, 12, 0);
    @(negedge clk);
    set_in(0, 12, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
    @(posedge clk);
    #1 check_out("t3_rise", 1, 2, 0, 4'b1101, 12, 0);
    hold_ok = 1'b1;
    for (int i = 1; i <= 59; i++) begin
      @(negedge clk);
      set_in(1, 12, 0, i, 0, 0, 0, 0, 0, 2, 0, 0);
      @(posedge clk);
      #1 if (ring !== 1'b1) hold_ok = 1'b0;
      @(negedge clk);
      set_in(0, 12, 0, i, 0, 0, 0, 0, 0, 2, 0, 0);
      @(posedge clk);
      #1 if (ring !== 1'b1) hold_ok = 1'b0;
    end
    n_vec++;
    if (!hold_ok) begin
      n_err++;
      $display("FAIL t3_hold: got ring=0 before the 60th tick, want ring=1 through 59 ticks");
    end
    @(negedge clk);
    set_in(1, 12, 1, 1, 0, 0, 0, 0, 0, 2, 0, 0);
    @(posedge clk);
    #1 check_out("t3_drop", 0, 2, 0, 4'b1101, 12, 0);

    // Asynchronous reset while ringing.
    @(negedge clk);
    set_in(1, 12, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
    @(posedge clk);
    #1 check_out("t6_match", 0, 2, 0, 4'b1101, 12, 0);
    @(negedge clk);
    set_in(0, 12, 0, 1, 0, 0, 0, 0, 0, 2, 0, 0);
    @(posedge clk);
    #1 check_out("t6_ring", 1, 2, 0, 4'b1101, 12, 0);
    #2 rst = 1'b0;
    #1 check_out("t6_async", 0, 0, 0, 4'b0000, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 check_out("t6_after", 0, 0, 0, 4'b0000, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
